serial_parity_deserializer: RTL and testbench
=============================================

Name: serial_parity_deserializer

Overview:
- Receiving end of the serial parity link: accepts a bit stream of frames (WIDTH data bits, LSB first, then one parity bit).
- Reassembles each data word and checks its parity with an XOR accumulator.
- Reports each word with a one-cycle valid pulse and an error flag.
- Sits downstream of the parity-generating serializer in the combinational/sequential exercise chain.

Parameters:
WIDTH, 8, number of data bits per frame; legal range 1..32.
ODD, 0, 0 = even parity (XOR of data and parity bit must be 0); 1 = odd parity (XOR must be 1).

Ports:
clk  input  1  clock; all state changes on rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  qualifies in_bit and in_start this cycle.
in_start  input  1  marks the first data bit of a frame; ignored unless in_valid=1.
in_bit  input  1  serial data or parity bit.
out_valid  output  1  one-cycle pulse: frame complete.
out_data  output  WIDTH  reassembled word; bit i = i-th data bit received.
out_parity_err  output  1  parity mismatch for the word on out_data.
out_abort  output  1  one-cycle pulse: frame restarted before completion.
busy  output  1  high while in DATA or PARITY state.

Behaviour:
- Reset (rst_n=0, async):
  - FSM goes to IDLE; bit counter, shift register and parity accumulator clear.
  - out_valid=0, out_data=0, out_parity_err=0, out_abort=0, busy=0.
  - Reset mid-frame discards the partial frame with no out_valid and no out_abort.
- Only cycles with in_valid=1 advance state; in_valid=0 cycles are stalls of any length and change nothing.
- States:
  - IDLE: in_valid & in_start -> capture in_bit as data bit 0, acc=in_bit, cnt=1.
    - Next state is DATA, or PARITY if WIDTH=1.
    - in_valid without in_start is ignored (stays IDLE).
  - DATA: each valid bit stores to position cnt, acc ^= in_bit, cnt++.
    - After bit WIDTH-1 is stored -> PARITY.
  - PARITY: a valid bit is the parity bit.
    - out_parity_err is computed from the accumulator and the parity bit: (acc ^ in_bit) != ODD.
    - Next state is IDLE.
- Output timing: out_valid pulses for exactly one cycle, the cycle after the parity bit is accepted (latency 1).
  - out_data and out_parity_err update in that same cycle.
  - Both hold until the next completed frame.
- Back-to-back frames: in_start with the first bit in the cycle right after the parity bit is accepted normally. It is sampled in IDLE; no bubble is required.
- in_start=1 with in_valid=1 while in DATA or PARITY:
  - Partial frame is dropped; out_abort pulses one cycle later.
  - The bit is taken as data bit 0 of a new frame (as in IDLE).
  - out_data and out_parity_err are unchanged.
- busy=1 exactly when the state is DATA or PARITY.
- out_valid and out_abort are never high in the same cycle.
- No X propagation: all registers have reset values.

Test Plan:
- Even parity, WIDTH=8, send 0xA5 (bits 1,0,1,0,0,1,0,1) then parity 0 -> one cycle later out_valid=1, out_data=8'hA5, out_parity_err=0; out_valid low the next cycle.
- Same frame with parity bit 1 -> out_data=8'hA5, out_parity_err=1.
- ODD=1: 0x01 with parity 0 -> out_parity_err=0; 0x01 with parity 1 -> out_parity_err=1.
- Send 0x3C with 0-3 random in_valid=0 stall cycles between bits, then immediately back-to-back 0xFF (parity 0) -> two out_valid pulses with out_data 8'h3C then 8'hFF, both with err=0.
- After 4 data bits, assert in_start with a new frame 0x81 (parity 0):
  - out_abort pulses once, with no out_valid for the dropped frame.
  - Then out_valid=1 with out_data=8'h81, err=0.
- Drive rst_n low for one cycle after 5 data bits, then send 0x5A (parity 0):
  - all outputs read 0 during reset, with no abort or valid pulse.
  - Then out_data=8'h5A, err=0.
- WIDTH=1: bit 1 then parity 1 -> out_data=1'b1, err=0.

Source files
------------

// File: rtl/serial_parity_deserializer.sv
// -----------------------------------------------------------------------------
// serial_parity_deserializer
//
// Receiving end of the serial parity link. A frame is WIDTH data bits, LSB
// first, then one parity bit. Each frame is reassembled into a word, its
// parity is checked against an XOR accumulator, and the result is reported
// with a one-cycle out_valid pulse. Only cycles with in_valid=1 advance the
// receiver; in_valid=0 cycles are stalls and change nothing.
//
// Parameters
//   WIDTH : data bits per frame (1..32)
//   ODD   : 0 = even parity (XOR of data and parity bit must be 0),
//           1 = odd parity  (XOR of data and parity bit must be 1)
//
// Ports
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   in_valid       in   qualifies in_bit / in_start this cycle
//   in_start       in   first data bit of a frame (only with in_valid)
//   in_bit         in   serial data or parity bit
//   out_valid      out  one-cycle pulse: frame complete
//   out_data       out  reassembled word, bit i = i-th data bit received
//   out_parity_err out  parity mismatch for the word on out_data
//   out_abort      out  one-cycle pulse: frame restarted before completion
//   busy           out  high while in DATA or PARITY
// -----------------------------------------------------------------------------
module serial_parity_deserializer #(
    parameter int WIDTH = 8,
    parameter int ODD   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_start,
    input  logic             in_bit,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity_err,
    output logic             out_abort,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    // After the first data bit the frame continues in DATA, except for a
    // one-bit word whose next bit is already the parity bit.
    localparam state_t AFTER_FIRST = (WIDTH == 1) ? PARITY : DATA;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               acc_q, acc_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_err_q, out_err_d;
    logic               out_abort_q, out_abort_d;

    logic               odd_bit;
    assign odd_bit = (ODD != 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            acc_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            out_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            out_abort_q <= out_abort_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        out_abort_d = 1'b0;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;

        if (in_valid) begin
            if (in_start) begin
                // A start always opens a new frame; if one was in progress it
                // is dropped and reported, but the published word is kept.
                out_abort_d = (state_q != IDLE);
                shift_d     = '0;
                shift_d[0]  = in_bit;
                acc_d       = in_bit;
                cnt_d       = CNT_W'(1);
                state_d     = AFTER_FIRST;
            end else begin
                case (state_q)
                    DATA: begin
                        for (int i = 0; i < WIDTH; i++) begin
                            if (cnt_q == CNT_W'(i)) begin
                                shift_d[i] = in_bit;
                            end
                        end
                        acc_d = acc_q ^ in_bit;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_d = PARITY;
                        end
                    end
                    PARITY: begin
                        out_valid_d = 1'b1;
                        out_data_d  = shift_q;
                        out_err_d   = ((acc_q ^ in_bit) != odd_bit);
                        state_d     = IDLE;
                    end
                    default: begin
                        // IDLE without a start bit: ignored.
                    end
                endcase
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_parity_err = out_err_q;
    assign out_abort      = out_abort_q;
    assign busy           = (state_q == DATA) || (state_q == PARITY);

endmodule

// File: tb/tb_serial_parity_deserializer.sv
module tb_serial_parity_deserializer;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_start, in_bit;

    logic       e_valid, e_err, e_abort, e_busy;
    logic [7:0] e_data;
    logic       o_valid, o_err, o_abort, o_busy;
    logic [7:0] o_data;
    logic       w_valid, w_err, w_abort, w_busy;
    logic [0:0] w_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_parity_deserializer #(.WIDTH(8), .ODD(0)) dut_even (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_start(in_start),
        .in_bit(in_bit), .out_valid(e_valid), .out_data(e_data),
        .out_parity_err(e_err), .out_abort(e_abort), .busy(e_busy));

    serial_parity_deserializer #(.WIDTH(8), .ODD(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_start(in_start),
        .in_bit(in_bit), .out_valid(o_valid), .out_data(o_data),
        .out_parity_err(o_err), .out_abort(o_abort), .busy(o_busy));

    serial_parity_deserializer #(.WIDTH(1), .ODD(0)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_start(in_start),
        .in_bit(in_bit), .out_valid(w_valid), .out_data(w_data),
        .out_parity_err(w_err), .out_abort(w_abort), .busy(w_busy));

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       err_even;
        logic       err_odd;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drives one valid bit; returns #1 after the edge that accepted it.
    task automatic send_bit(input logic st, input logic b);
        in_valid = 1'b1;
        in_start = st;
        in_bit   = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_start = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic stall(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input int max_stall);
        for (int i = 0; i < 8; i++) begin
            if (max_stall > 0) stall($urandom_range(0, max_stall));
            send_bit(i == 0, d[i]);
        end
        if (max_stall > 0) stall($urandom_range(0, max_stall));
        send_bit(1'b0, p);
    endtask

    initial begin
        //            data   par  err_even err_odd
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h01, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h01, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'hFF, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b1; in_valid = 1'b0; in_start = 1'b0; in_bit = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", e_valid, 0);
        chk("rst_data",  e_data,  0);
        chk("rst_err",   e_err,   0);
        chk("rst_abort", e_abort, 0);
        chk("rst_busy",  e_busy,  0);
        chk("rst_w1_data", w_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        stall(2);

        // Table-driven frames, checked on both parity senses.
        for (int k = 0; k < 7; k++) begin
            send_frame(vecs[k].data, vecs[k].par, 0);
            chk($sformatf("v%0d_valid", k), e_valid, 1);
            chk($sformatf("v%0d_data", k),  e_data,  vecs[k].data);
            chk($sformatf("v%0d_err_even", k), e_err, vecs[k].err_even);
            chk($sformatf("v%0d_odd_valid", k), o_valid, 1);
            chk($sformatf("v%0d_err_odd", k), o_err, vecs[k].err_odd);
            chk($sformatf("v%0d_busy", k), e_busy, 0);
            stall(1);
            chk($sformatf("v%0d_valid_low", k), e_valid, 0);
            chk($sformatf("v%0d_data_hold", k), e_data, vecs[k].data);
            chk($sformatf("v%0d_err_hold", k),  e_err, vecs[k].err_even);
        end

        // Stalled 0x3C followed by back-to-back 0xFF with no bubble.
        send_frame(8'h3C, 1'b0, 3);
        chk("b2b_3c_valid", e_valid, 1);
        chk("b2b_3c_data",  e_data,  8'h3C);
        chk("b2b_3c_err",   e_err,   0);
        send_bit(1'b1, 1'b1);
        chk("b2b_ff_start_valid_low", e_valid, 0);
        chk("b2b_ff_busy", e_busy, 1);
        chk("b2b_ff_no_abort", e_abort, 0);
        for (int i = 1; i < 8; i++) send_bit(1'b0, 1'b1);
        chk("b2b_ff_before_par_data", e_data, 8'h3C);
        send_bit(1'b0, 1'b0);
        chk("b2b_ff_valid", e_valid, 1);
        chk("b2b_ff_data",  e_data,  8'hFF);
        chk("b2b_ff_err",   e_err,   0);
        stall(1);

        // Abort: 4 data bits of 0x0F, then restart with 0x81.
        for (int i = 0; i < 4; i++) send_bit(i == 0, 1'b1);
        stall(2);
        chk("abort_pre_busy", e_busy, 1);
        send_bit(1'b1, 1'b1);
        chk("abort_pulse", e_abort, 1);
        chk("abort_no_valid", e_valid, 0);
        chk("abort_data_kept", e_data, 8'hFF);
        chk("abort_err_kept", e_err, 0);
        send_bit(1'b0, 1'b0);
        chk("abort_pulse_end", e_abort, 0);
        for (int i = 2; i < 8; i++) send_bit(1'b0, (i == 7));
        chk("abort_no_valid_yet", e_valid, 0);
        send_bit(1'b0, 1'b0);
        chk("abort_81_valid", e_valid, 1);
        chk("abort_81_data",  e_data,  8'h81);
        chk("abort_81_err",   e_err,   0);
        chk("abort_81_abort_low", e_abort, 0);
        stall(1);

        // Reset after 5 data bits of 0xFF, then 0x5A.
        for (int i = 0; i < 5; i++) send_bit(i == 0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", e_valid, 0);
        chk("mrst_data",  e_data,  0);
        chk("mrst_err",   e_err,   0);
        chk("mrst_abort", e_abort, 0);
        chk("mrst_busy",  e_busy,  0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        stall(1);
        chk("mrst_after_valid", e_valid, 0);
        chk("mrst_after_abort", e_abort, 0);
        send_frame(8'h5A, 1'b0, 0);
        chk("mrst_5a_valid", e_valid, 1);
        chk("mrst_5a_data",  e_data,  8'h5A);
        chk("mrst_5a_err",   e_err,   0);
        stall(1);

        // Width 1: data bit 1, parity 1.
        send_bit(1'b1, 1'b1);
        chk("w1_busy", w_busy, 1);
        send_bit(1'b0, 1'b1);
        chk("w1_valid", w_valid, 1);
        chk("w1_data",  w_data,  1);
        chk("w1_err",   w_err,   0);
        chk("w1_busy_end", w_busy, 0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        chk("w1b_valid", w_valid, 1);
        chk("w1b_data",  w_data,  0);
        chk("w1b_err",   w_err,   1);
        stall(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
